pc_ras_seq: RTL and testbench

- Parametrised next-generation program counter with an integrated return-address stack (RAS).
- Sits in the fetch stage and drives the instruction-memory address.
- Supports increment, absolute jump, conditional PC-relative branch, call (push) and return (pop), plus stall.
- Carries its own stack, so RET needs no external stack feed.

---
 rtl/pc_ras_seq_pkg.sv | 25 ++
 rtl/pc_ras_seq_if.sv | 52 +++++
 rtl/pc_ras_seq_ras_stack.sv | 64 ++++++
 rtl/pc_ras_seq.sv | 137 +++++++++++++
 tb/tb_pc_ras_seq.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_ras_seq_pkg.sv
// pc_pkg: shared definitions for the program counter / return-address stack
// slice.
//   pc_op_t     3-bit operation encoding. Codes 5-7 are not named and decode
//               as OP_NEXT.
//   ADDR_W_DEF  default address width.
//   sp_w()      width of a 0..depth occupancy count.
package pc_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRA  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_t;

  // The count must reach 'depth' itself, so it needs one bit more than the
  // index.
  function automatic int sp_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_ras_seq_if.sv
// pc_ras_seq_if: control/status bundle of the fetch-stage program counter.
//   master modport (fetch control side):
//     drives  stall, op, cond, target, offset, clr_err
//             and irq, which exists only when PC_IRQ_EN is defined
//     samples pc, ras_empty, ras_full, ras_ovf, ras_udf, ras_sp
//   slave modport (pc_ras_seq): the same signals with the opposite direction.
//   ras_sp is the stack occupancy, exposed for observation.
// Handshake: there is no valid/ready pair. Every falling clock edge with
// stall=0 consumes one op. stall=1 freezes all state. Outputs are valid
// throughout the cycle that follows the edge that produced them.
// Optional feature: PC_IRQ_EN adds the level-sensitive irq input.
interface pc_ras_seq_if
  import pc_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAS_DEPTH = 8
);
  localparam int SP_W = sp_w(RAS_DEPTH);

  logic              stall;
  logic [2:0]        op;
  logic              cond;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] offset;
  logic              clr_err;
`ifdef PC_IRQ_EN
  logic              irq;
`endif
  logic [ADDR_W-1:0] pc;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_ovf;
  logic              ras_udf;
  logic [SP_W-1:0]   ras_sp;

  modport master (
`ifdef PC_IRQ_EN
    output irq,
`endif
    output stall, op, cond, target, offset, clr_err,
    input  pc, ras_empty, ras_full, ras_ovf, ras_udf, ras_sp
  );

  modport slave (
`ifdef PC_IRQ_EN
    input  irq,
`endif
    input  stall, op, cond, target, offset, clr_err,
    output pc, ras_empty, ras_full, ras_ovf, ras_udf, ras_sp
  );

endinterface

// File: rtl/pc_ras_seq_ras_stack.sv
// ras_stack: circular return-address stack.
//   clk        state updates on the falling edge
//   rst        asynchronous, active-low
//   push       write push_data at the top. When the stack is full this
//              overwrites the oldest entry.
//   pop        drop the top entry. Ignored while empty.
//   push_data  value to push
//   top        entry at write index - 1
//   empty      count == 0
//   full       count == RAS_DEPTH
//   count      occupancy, from 0 to RAS_DEPTH
// RAS_DEPTH must be a power of two so that the index wraps naturally.
module ras_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            top,
  output logic                         empty,
  output logic                         full,
  output logic [sp_w(RAS_DEPTH)-1:0]   count
);
  localparam int IDX_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = sp_w(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  cnt;

  assign rd_idx = wr_idx - IDX_W'(1);
  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_W'(RAS_DEPTH));
  assign top    = mem[rd_idx];
  assign count  = cnt;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx <= '0;
      cnt    <= '0;
    end else if (push) begin
      // When the stack is full, wr_idx already points at the oldest entry.
      // Advancing it overwrites that entry and the count saturates.
      wr_idx <= wr_idx + IDX_W'(1);
      if (!full) cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_idx <= rd_idx;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  // The storage has no reset because its contents do not matter until
  // something is pushed.
  always_ff @(negedge clk) begin
    if (push && rst) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_ras_seq.sv
// pc_ras_seq: fetch-stage program counter with an integrated return-address
// stack.
//   clk  state updates on the falling edge
//   rst  asynchronous, active-low. Loads RESET_VEC and empties the stack.
//   bus  pc_ras_seq_if.slave
//          inputs : stall, op, cond, target, offset, clr_err
//                   and irq, which exists only when PC_IRQ_EN is defined
//          outputs: pc, ras_empty, ras_full, ras_ovf (sticky),
//                   ras_udf (sticky), ras_sp
// Ops: NEXT, JMP, BRA (taken when cond=1), CALL (push pc+1), RET (pop).
// Codes 5-7 act as NEXT.
// Optional feature PC_IRQ_EN: irq=1 takes priority over op. It pushes the
// current pc and jumps to IRQ_VEC. irq is ignored while pc lies in
// IRQ_VEC..IRQ_VEC+3.
module pc_ras_seq
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
`ifdef PC_IRQ_EN
  ,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(4)
`endif
) (
  input logic         clk,
  input logic         rst,
  pc_ras_seq_if.slave bus
);
  localparam int SP_W = sp_w(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic              ovf_q;
  logic              udf_q;
  logic              ovf_set;
  logic              udf_set;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty_w;
  logic              ras_full_w;
  logic [SP_W-1:0]   ras_cnt;
  pc_op_t            op_w;

  assign op_w   = pc_op_t'(bus.op);
  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef PC_IRQ_EN
  logic [ADDR_W-1:0] irq_rel;
  logic              irq_take;

  // The subtraction is unsigned, so the window test still works when
  // IRQ_VEC+3 wraps past the top of the address space.
  assign irq_rel  = pc_q - IRQ_VEC;
  assign irq_take = bus.irq && (irq_rel >= ADDR_W'(4));
`endif

  always_comb begin
    pc_nxt    = pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (!bus.stall) begin
      pc_nxt = pc_inc;
`ifdef PC_IRQ_EN
      if (irq_take) begin
        // Push the unexecuted instruction so that RET re-executes it.
        push      = 1'b1;
        push_data = pc_q;
        pc_nxt    = IRQ_VEC;
        ovf_set   = ras_full_w;
      end else
`endif
      begin
        case (op_w)
          OP_JMP: pc_nxt = bus.target;
          OP_BRA: if (bus.cond) pc_nxt = pc_q + bus.offset;
          OP_CALL: begin
            push    = 1'b1;
            pc_nxt  = bus.target;
            ovf_set = ras_full_w;
          end
          OP_RET: begin
            if (ras_empty_w) begin
              udf_set = 1'b1;
            end else begin
              pop    = 1'b1;
              pc_nxt = ras_top;
            end
          end
          default: pc_nxt = pc_inc;
        endcase
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q  <= pc_nxt;
      // A new error in the same cycle as clr_err wins, so the flag stays set.
      ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
      udf_q <= udf_set | (udf_q & ~bus.clr_err);
    end
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (ras_top),
    .empty     (ras_empty_w),
    .full      (ras_full_w),
    .count     (ras_cnt)
  );

  assign bus.pc        = pc_q;
  assign bus.ras_empty = ras_empty_w;
  assign bus.ras_full  = ras_full_w;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_udf   = udf_q;
  assign bus.ras_sp    = ras_cnt;

endmodule

// File: tb/tb_pc_ras_seq.sv
module tb_pc_ras_seq;
  import pc_pkg::*;

  localparam int AW = 16;
  localparam int DEPTH = 8;
  localparam int EW = AW + 4 + 4;

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        cond;
    logic [15:0] target;
    logic [15:0] offset;
    logic        clr_err;
    logic [15:0] e_pc;
    logic [3:0]  e_sp;
    logic        e_ovf;
    logic        e_udf;
    string       nm;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  vec_t          vecs[$];

  pc_ras_seq_if #(.ADDR_W(AW), .RAS_DEPTH(DEPTH)) bus ();

  pc_ras_seq #(.ADDR_W(AW), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  // Expected-output record. empty and full are decoded from the expected sp.
  function automatic logic [EW-1:0] pack_exp(input logic [15:0] p, input logic [3:0] s,
                                             input logic o, input logic u);
    return {p, (s == 4'd0), (s == 4'(DEPTH)), o, u, s};
  endfunction

  // scoreboard
  task automatic check_now();
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    string         nm;
    got = {bus.pc, bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_udf, bus.ras_sp};
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard: got output with empty queue, required a queued expectation");
      return;
    end
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h e=%b f=%b ovf=%b udf=%b sp=%0d, required pc=%h e=%b f=%b ovf=%b udf=%b sp=%0d",
               nm, got[EW-1 -: 16], got[7], got[6], got[5], got[4], got[3:0],
               exp[EW-1 -: 16], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // driver tasks: inputs change just after the rising edge, the DUT updates
  // on the falling edge, and the outputs are sampled on the next rising edge.
  task automatic step(input logic st, input logic [2:0] o, input logic c,
                      input logic [15:0] tg, input logic [15:0] off, input logic ce,
                      input logic [15:0] e_pc, input logic [3:0] e_sp,
                      input logic e_ovf, input logic e_udf, input string nm);
    bus.stall   = st;
    bus.op      = o;
    bus.cond    = c;
    bus.target  = tg;
    bus.offset  = off;
    bus.clr_err = ce;
    exp_q.push_back(pack_exp(e_pc, e_sp, e_ovf, e_udf));
    name_q.push_back(nm);
    @(negedge clk);
    @(posedge clk);
    check_now();
  endtask

  task automatic add(input logic st, input logic [2:0] o, input logic c,
                     input logic [15:0] tg, input logic [15:0] off, input logic ce,
                     input logic [15:0] e_pc, input logic [3:0] e_sp,
                     input logic e_ovf, input logic e_udf, input string nm);
    vec_t v;
    v.stall = st; v.op = o; v.cond = c; v.target = tg; v.offset = off;
    v.clr_err = ce; v.e_pc = e_pc; v.e_sp = e_sp; v.e_ovf = e_ovf; v.e_udf = e_udf;
    v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].stall, vecs[i].op, vecs[i].cond, vecs[i].target, vecs[i].offset,
           vecs[i].clr_err, vecs[i].e_pc, vecs[i].e_sp, vecs[i].e_ovf, vecs[i].e_udf,
           vecs[i].nm);
    vecs.delete();
  endtask

  function automatic logic [15:0] a_of(input int i);
    return 16'h1000 + 16'(i * 16);
  endfunction

  initial begin
    logic [3:0] sp;
    logic       ovf;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.stall = 1'b0; bus.op = 3'd0; bus.cond = 1'b0;
    bus.target = '0; bus.offset = '0; bus.clr_err = 1'b0;
`ifdef PC_IRQ_EN
    bus.irq = 1'b0;
`endif
    @(posedge clk);
    exp_q.push_back(pack_exp(16'h0000, 4'd0, 1'b0, 1'b0));
    name_q.push_back("reset_state");
    check_now();
    rst = 1'b1;

    // count up from the reset vector
    add(0, OP_NEXT, 0, 16'h0, 16'h0, 0, 16'h0001, 0, 0, 0, "next_1");
    add(0, OP_NEXT, 0, 16'h0, 16'h0, 0, 16'h0002, 0, 0, 0, "next_2");
    add(0, OP_NEXT, 0, 16'h0, 16'h0, 0, 16'h0003, 0, 0, 0, "next_3");
    run_vecs();

    // asynchronous reset mid-run, with no clock edge in between
    rst = 1'b0;
    #1;
    exp_q.push_back(pack_exp(16'h0000, 4'd0, 1'b0, 1'b0));
    name_q.push_back("async_reset");
    check_now();
    #1 rst = 1'b1;

    add(0, OP_JMP,  0, 16'h00FF, 16'h0,    0, 16'h00FF, 0, 0, 0, "jmp_ff");
    add(0, OP_BRA,  1, 16'h0,    16'hFFFE, 0, 16'h00FD, 0, 0, 0, "bra_taken_neg");
    add(0, OP_BRA,  0, 16'h0,    16'h0010, 0, 16'h00FE, 0, 0, 0, "bra_not_taken");
    add(0, OP_JMP,  0, 16'h0010, 16'h0,    0, 16'h0010, 0, 0, 0, "jmp_10");
    add(0, OP_CALL, 0, 16'h0100, 16'h0,    0, 16'h0100, 1, 0, 0, "call_100");
    add(0, OP_CALL, 0, 16'h0200, 16'h0,    0, 16'h0200, 2, 0, 0, "call_200");
    add(0, OP_RET,  0, 16'h0,    16'h0,    0, 16'h0101, 1, 0, 0, "ret_101");
    add(0, OP_RET,  0, 16'h0,    16'h0,    0, 16'h0011, 0, 0, 0, "ret_11");
    add(1, OP_CALL, 0, 16'h0300, 16'h0,    0, 16'h0011, 0, 0, 0, "stall_call_1");
    add(1, OP_CALL, 0, 16'h0300, 16'h0,    1, 16'h0011, 0, 0, 0, "stall_call_2");
    add(0, OP_CALL, 0, 16'h0300, 16'h0,    0, 16'h0300, 1, 0, 0, "call_300");
    add(1, OP_RET,  0, 16'h0,    16'h0,    0, 16'h0300, 1, 0, 0, "stall_ret_1");
    add(1, OP_RET,  0, 16'h0,    16'h0,    0, 16'h0300, 1, 0, 0, "stall_ret_2");
    add(0, OP_RET,  0, 16'h0,    16'h0,    0, 16'h0012, 0, 0, 0, "ret_12");
    add(0, OP_JMP,  0, 16'hFFFF, 16'h0,    0, 16'hFFFF, 0, 0, 0, "jmp_ffff");
    add(0, OP_NEXT, 0, 16'h0,    16'h0,    0, 16'h0000, 0, 0, 0, "next_wrap");
    add(0, 3'd5,    1, 16'h0555, 16'h0,    0, 16'h0001, 0, 0, 0, "op5_next");
    add(0, 3'd7,    1, 16'h0777, 16'h0,    0, 16'h0002, 0, 0, 0, "op7_next");
    add(0, OP_BRA,  1, 16'h0,    16'h0010, 0, 16'h0012, 0, 0, 0, "bra_taken_pos");
    run_vecs();

    // nine CALLs into a stack of eight; the first return address is lost
    sp = 4'd0;
    ovf = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      step(0, OP_JMP, 0, a_of(i), 16'h0, 0, a_of(i), sp, ovf, 0, $sformatf("ovf_jmp_%0d", i));
      if (sp == 4'(DEPTH)) ovf = 1'b1;
      else sp = sp + 4'd1;
      step(0, OP_CALL, 0, 16'h2000 + 16'(i), 16'h0, 0, 16'h2000 + 16'(i), sp, ovf, 0,
           $sformatf("ovf_call_%0d", i));
    end
    for (int k = 0; k < 8; k++)
      step(0, OP_RET, 0, 16'h0, 16'h0, 0, a_of(8 - k) + 16'd1, 4'(7 - k), 1, 0,
           $sformatf("ovf_ret_%0d", k));
    step(0, OP_RET,  0, 16'h0, 16'h0, 0, a_of(1) + 16'd2, 0, 1, 1, "udf_ret");
    step(1, OP_NEXT, 0, 16'h0, 16'h0, 1, a_of(1) + 16'd2, 0, 1, 1, "stall_beats_clr");
    step(0, OP_RET,  0, 16'h0, 16'h0, 1, a_of(1) + 16'd3, 0, 0, 1, "clr_vs_new_udf");
    step(0, OP_NEXT, 0, 16'h0, 16'h0, 1, a_of(1) + 16'd4, 0, 0, 0, "clr_err");

`ifdef PC_IRQ_EN
    step(0, OP_JMP, 0, 16'h0030, 16'h0, 0, 16'h0030, 0, 0, 0, "irq_pre_jmp");
    bus.irq = 1'b1;
    step(0, OP_JMP, 0, 16'h0500, 16'h0, 0, 16'h0004, 1, 0, 0, "irq_entry");
    step(0, OP_NEXT, 0, 16'h0, 16'h0, 0, 16'h0005, 1, 0, 0, "irq_masked_window");
    bus.irq = 1'b0;
    step(0, OP_RET, 0, 16'h0, 16'h0, 0, 16'h0030, 0, 0, 0, "irq_return");
`endif

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
